id_ex_skid_stage: RTL and testbench

//  Decode->execute pipeline stage for the vector filter GPU, with valid/ready flow control.

---
 rtl/id_ex_skid_stage_if.sv | 39 +++
 rtl/id_ex_skid_stage.sv | 95 +++++++++
 tb/tb_id_ex_skid_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_skid_stage_if.sv
// Decode->execute handshake bundle: decode-side beat in, execute-side beat out, stall profile.
// The stage itself connects through the slave modport.
interface id_ex_skid_stage_if #(
    parameter int N     = 18,
    parameter int LANES = 3,
    parameter int AW    = 4,
    parameter int CW    = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*N-1:0]   rd1_in;
    logic [LANES*N-1:0]   rd2_in;
    logic [LANES*N-1:0]   ext_in;
    logic [AW-1:0]        ra1_in;
    logic [AW-1:0]        ra2_in;
    logic [AW-1:0]        wa3_in;
    logic [9:0]           ctrl_in;

    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*N-1:0]   rd1_o;
    logic [LANES*N-1:0]   rd2_o;
    logic [LANES*N-1:0]   ext_o;
    logic [AW-1:0]        ra1_o;
    logic [AW-1:0]        ra2_o;
    logic [AW-1:0]        wa3_o;
    logic [9:0]           ctrl_o;
    logic [CW-1:0]        stall_cnt;

    modport slave (
        input  in_valid, rd1_in, rd2_in, ext_in, ra1_in, ra2_in, wa3_in, ctrl_in, out_ready,
        output in_ready, out_valid, rd1_o, rd2_o, ext_o, ra1_o, ra2_o, wa3_o, ctrl_o, stall_cnt
    );

    modport master (
        output in_valid, rd1_in, rd2_in, ext_in, ra1_in, ra2_in, wa3_in, ctrl_in, out_ready,
        input  in_ready, out_valid, rd1_o, rd2_o, ext_o, ra1_o, ra2_o, wa3_o, ctrl_o, stall_cnt
    );
endinterface

// File: rtl/id_ex_skid_stage.sv
// Decode->execute pipeline register with a two-entry (main + skid) buffer,
// registered in_ready, branch flush and a saturating execute-stall counter.
module id_ex_skid_stage #(
    parameter int N     = 18,
    parameter int LANES = 3,
    parameter int AW    = 4,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    id_ex_skid_stage_if.slave     bus
);
    localparam int W = 3*LANES*N + 3*AW + 10;
    // ctrl bits with side effects: FlagWr(5), Branch(3), MemWr(2), RegWr(0)
    localparam logic [9:0] SIDE_FX_MASK = 10'b00_0010_1101;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t         r_state;
    logic [W-1:0]   r_main;
    logic [W-1:0]   r_skid;
    logic           r_out_valid;
    logic           r_in_ready;
    logic [CW-1:0]  r_stall;

    logic [W-1:0]   w_in;
    logic [9:0]     w_main_ctrl;

    assign w_in = {bus.rd1_in, bus.rd2_in, bus.ext_in,
                   bus.ra1_in, bus.ra2_in, bus.wa3_in, bus.ctrl_in};

    assign {bus.rd1_o, bus.rd2_o, bus.ext_o,
            bus.ra1_o, bus.ra2_o, bus.wa3_o, w_main_ctrl} = r_main;

    assign bus.ctrl_o    = r_out_valid ? w_main_ctrl : (w_main_ctrl & ~SIDE_FX_MASK);
    assign bus.out_valid = r_out_valid;
    assign bus.in_ready  = r_in_ready;
    assign bus.stall_cnt = r_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_stall     <= '0;
        end else begin
            if (r_out_valid && !bus.out_ready && !flush && r_stall != '1)
                r_stall <= r_stall + CW'(1);

            if (flush) begin
                r_state     <= EMPTY;
                r_out_valid <= 1'b0;
                r_in_ready  <= 1'b1;
            end else begin
                unique case (r_state)
                    EMPTY: begin
                        if (bus.in_valid) begin
                            r_main      <= w_in;
                            r_state     <= BUSY;
                            r_out_valid <= 1'b1;
                        end
                    end
                    BUSY: begin
                        if (bus.in_valid && bus.out_ready) begin
                            r_main <= w_in;
                        end else if (bus.in_valid) begin
                            r_skid     <= w_in;
                            r_state    <= FULL;
                            r_in_ready <= 1'b0;
                        end else if (bus.out_ready) begin
                            r_state     <= EMPTY;
                            r_out_valid <= 1'b0;
                        end
                    end
                    FULL: begin
                        // input is ignored here: in_ready is low while skid is occupied
                        if (bus.out_ready) begin
                            r_main     <= r_skid;
                            r_state    <= BUSY;
                            r_in_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed + randomized bench for id_ex_skid_stage against a queue-based model
// of a two-deep in-order buffer.
module tb_id_ex_skid_stage;
    localparam int N     = 18;
    localparam int LANES = 3;
    localparam int AW    = 4;
    localparam int CW    = 4;

    typedef struct packed {
        logic [LANES*N-1:0] rd1;
        logic [LANES*N-1:0] rd2;
        logic [LANES*N-1:0] ext;
        logic [AW-1:0]      ra1;
        logic [AW-1:0]      ra2;
        logic [AW-1:0]      wa3;
        logic [9:0]         ctrl;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    id_ex_skid_stage_if #(.N(N), .LANES(LANES), .AW(AW), .CW(CW)) bus ();

    id_ex_skid_stage #(.N(N), .LANES(LANES), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    beat_t in_beat;
    assign bus.rd1_in  = in_beat.rd1;
    assign bus.rd2_in  = in_beat.rd2;
    assign bus.ext_in  = in_beat.ext;
    assign bus.ra1_in  = in_beat.ra1;
    assign bus.ra2_in  = in_beat.ra2;
    assign bus.wa3_in  = in_beat.wa3;
    assign bus.ctrl_in = in_beat.ctrl;

    beat_t q[$];
    int    m_stall;
    bit    zero_flag;
    int    total = 0;
    int    bad   = 0;

    function automatic beat_t rand_beat();
        beat_t b;
        b.rd1  = {$urandom, $urandom};
        b.rd2  = {$urandom, $urandom};
        b.ext  = {$urandom, $urandom};
        b.ra1  = AW'($urandom);
        b.ra2  = AW'($urandom);
        b.wa3  = AW'($urandom_range(8, 15));
        b.ctrl = 10'($urandom);
        return b;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check();
        cmp("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        cmp("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
        cmp("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
        if (q.size() > 0) begin
            cmp("rd1_o",  64'(bus.rd1_o),  64'(q[0].rd1));
            cmp("rd2_o",  64'(bus.rd2_o),  64'(q[0].rd2));
            cmp("ext_o",  64'(bus.ext_o),  64'(q[0].ext));
            cmp("ra1_o",  64'(bus.ra1_o),  64'(q[0].ra1));
            cmp("ra2_o",  64'(bus.ra2_o),  64'(q[0].ra2));
            cmp("wa3_o",  64'(bus.wa3_o),  64'(q[0].wa3));
            cmp("ctrl_o", 64'(bus.ctrl_o), 64'(q[0].ctrl));
        end else begin
            cmp("ctrl_masked", 64'(bus.ctrl_o & 10'h02D), 64'd0);
            if (zero_flag) begin
                cmp("rst_rd1", 64'(bus.rd1_o), 64'd0);
                cmp("rst_rd2", 64'(bus.rd2_o), 64'd0);
                cmp("rst_ext", 64'(bus.ext_o), 64'd0);
                cmp("rst_adr", 64'({bus.ra1_o, bus.ra2_o, bus.wa3_o}), 64'd0);
                cmp("rst_ctrl", 64'(bus.ctrl_o), 64'd0);
            end
        end
    endtask

    // One clock edge: advance the model with the inputs as they stood at the edge, then check.
    task automatic step();
        bit acc;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_stall   = 0;
            zero_flag = 1'b1;
        end else begin
            if (q.size() > 0 && !bus.out_ready && !flush && m_stall < (1 << CW) - 1)
                m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                acc = bus.in_valid && (q.size() < 2);
                if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
                if (acc) begin
                    q.push_back(in_beat);
                    zero_flag = 1'b0;
                end
            end
        end
        #1;
        check();
    endtask

    initial begin
        beat_t b;
        logic [LANES*N-1:0] pat;
        m_stall      = 0;
        zero_flag    = 1'b1;
        reset        = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        in_beat      = '0;
        step();
        step();
        reset = 1'b0;
        step();

        // back-to-back beats with execute always ready
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b = rand_beat();
            b.rd1[N-1:0] = N'(i);
            in_beat = b;
            bus.in_valid = 1'b1;
            step();
            cmp("b2b_lane0", 64'(bus.rd1_o[N-1:0]), 64'(i));
        end
        bus.in_valid = 1'b0;
        step();

        // fill to FULL while stalled, then drain
        bus.out_ready = 1'b0;
        b = rand_beat(); b.wa3 = 4'd5; in_beat = b; bus.in_valid = 1'b1;
        step();
        b = rand_beat(); b.wa3 = 4'd6; in_beat = b;
        step();
        cmp("full_in_ready", 64'(bus.in_ready), 64'd0);
        cmp("full_hold_A", 64'(bus.wa3_o), 64'd5);
        b = rand_beat(); b.wa3 = 4'd9; in_beat = b;
        step();
        cmp("ignored_while_full", 64'(bus.wa3_o), 64'd5);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        cmp("drain_B", 64'(bus.wa3_o), 64'd6);
        step();

        // flush while FULL with a live input beat
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        in_beat = rand_beat(); step();
        in_beat = rand_beat(); step();
        b = rand_beat(); b.wa3 = 4'd7; in_beat = b;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        cmp("flush_ov", 64'(bus.out_valid), 64'd0);
        step();

        // lane packing pass-through
        pat = {18'h3FFFF, 18'h00001, 18'h2AAAA};
        b = rand_beat(); b.rd1 = pat; in_beat = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        cmp("lanes_rd1", 64'(bus.rd1_o), 64'(pat));
        cmp("lane0", 64'(bus.rd1_o[N-1:0]), 64'h2AAAA);

        // long stall saturates the counter
        for (int i = 0; i < 20; i++) step();
        cmp("stall_sat", 64'(bus.stall_cnt), 64'd15);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmp("stall_clr", 64'(bus.stall_cnt), 64'd0);

        // reset while BUSY and stalled
        in_beat = rand_beat(); bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_beat       = rand_beat();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            reset         = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
